// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage engine between EX/MEM and MEM/WB.
// Turns loads and stores into word-aligned req/ack bus transactions.
// Byte enables and store data are lane-steered for the access size.
// Load data is extracted from the returned word and sign/zero extended.
// Non-memory results pass straight through with one cycle of latency.
// Only WordSize = 32 (four byte lanes) is supported.
// Optional feature macro: MEM_MISALIGN_EXC_EN. When defined, misaligned
// halfword/word accesses raise misalign_exc and are not issued to the bus.
module mem_access_unit #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_in,
    input  logic [4:0]          rdn_in,
    input  logic [WordSize-1:0] alu_out_in,
    input  logic [WordSize-1:0] mem_data_in,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    output logic                stall,
    output logic                bus_req,
    output logic                bus_we,
    output logic [WordSize-1:0] bus_addr,
    output logic [3:0]          bus_be,
    output logic [WordSize-1:0] bus_wdata,
    input  logic                bus_ack,
    input  logic [WordSize-1:0] bus_rdata,
`ifdef MEM_MISALIGN_EXC_EN
    output logic                misalign_exc,
`endif
    output logic                wb_valid,
    output logic [4:0]          rdn,
    output logic [WordSize-1:0] wb_data
);

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    state_t      state;
    logic [1:0]  cap_lo;
    logic [2:0]  cap_f3;
    logic [4:0]  cap_rdn;
    logic        cap_load;
    logic        mem_op;
    logic        misaligned;
    logic        issue;

    // funct3[1:0]: 00 byte, 01 half, 1x word (so 011/110/111 fall to word).
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    assign mem_op = valid_in & (mem_read | mem_write);

`ifdef MEM_MISALIGN_EXC_EN
    assign misaligned = ((funct3[1:0] == 2'b01) & alu_out_in[0]) |
                        (funct3[1] & (alu_out_in[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign issue = mem_op & ~misaligned;

    // Upstream hold: while issuing, and in BUS until the acknowledge arrives.
    assign stall = rstn & ((state == BUS) ? ~bus_ack : issue);

    // Single FSM: IDLE accepts instructions, BUS waits for the acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            wb_valid  <= 1'b0;
            rdn       <= 5'd0;
            wb_data   <= '0;
            cap_lo    <= 2'b00;
            cap_f3    <= 3'b000;
            cap_rdn   <= 5'd0;
            cap_load  <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_EXC_EN
            misalign_exc <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mem_op && misaligned) begin
                        wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
                        misalign_exc <= 1'b1;
`endif
                    end else if (mem_op) begin
                        cap_lo    <= alu_out_in[1:0];
                        cap_f3    <= funct3;
                        cap_rdn   <= rdn_in;
                        cap_load  <= mem_read;
                        bus_req   <= 1'b1;
                        bus_we    <= ~mem_read;
                        bus_addr  <= {alu_out_in[WordSize-1:2], 2'b00};
                        bus_be    <= byte_enables(funct3, alu_out_in[1:0]);
                        bus_wdata <= mem_read ? '0 : store_data(funct3, mem_data_in);
                        wb_valid  <= 1'b0;
                        state     <= BUS;
                    end else if (valid_in) begin
                        wb_valid <= 1'b1;
                        rdn      <= rdn_in;
                        wb_data  <= alu_out_in;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= 4'b0000;
                        bus_wdata <= '0;
                        wb_valid  <= 1'b1;
                        rdn       <= cap_load ? cap_rdn : 5'd0;
                        wb_data   <= cap_load ? load_extract(cap_f3, cap_lo, bus_rdata) : '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
